// File: rtl/jelly_axi4_write_limiter.sv
// AXI4 write-channel limiter: caps accepted-but-unresponded bursts and holds W beats until their AW is accepted.
// Optional error capture is enabled by defining JELLY_AXI4_WRITE_LIMITER_ERR_EN.
module jelly_axi4_write_limiter #(
  parameter int AXI4_ID_WIDTH   = 6,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_SIZE  = 2,
  parameter int AXI4_DATA_WIDTH = (8 << AXI4_DATA_SIZE),
  parameter int AXI4_STRB_WIDTH = (1 << AXI4_DATA_SIZE),
  parameter int AXI4_LEN_WIDTH  = 8,
  parameter int AXI4_QOS_WIDTH  = 4,
  parameter int MAX_OUTSTANDING = 15,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                       aresetn,
  input  logic                       aclk,

  input  logic [AXI4_ID_WIDTH-1:0]   s_axi4_awid,
  input  logic [AXI4_ADDR_WIDTH-1:0] s_axi4_awaddr,
  input  logic [AXI4_LEN_WIDTH-1:0]  s_axi4_awlen,
  input  logic [2:0]                 s_axi4_awsize,
  input  logic [1:0]                 s_axi4_awburst,
  input  logic                       s_axi4_awlock,
  input  logic [3:0]                 s_axi4_awcache,
  input  logic [2:0]                 s_axi4_awprot,
  input  logic [AXI4_QOS_WIDTH-1:0]  s_axi4_awqos,
  input  logic [3:0]                 s_axi4_awregion,
  input  logic                       s_axi4_awvalid,
  output logic                       s_axi4_awready,
  input  logic [AXI4_DATA_WIDTH-1:0] s_axi4_wdata,
  input  logic [AXI4_STRB_WIDTH-1:0] s_axi4_wstrb,
  input  logic                       s_axi4_wlast,
  input  logic                       s_axi4_wvalid,
  output logic                       s_axi4_wready,
  output logic [AXI4_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                 s_axi4_bresp,
  output logic                       s_axi4_bvalid,
  input  logic                       s_axi4_bready,

  output logic [AXI4_ID_WIDTH-1:0]   m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0] m_axi4_awaddr,
  output logic [AXI4_LEN_WIDTH-1:0]  m_axi4_awlen,
  output logic [2:0]                 m_axi4_awsize,
  output logic [1:0]                 m_axi4_awburst,
  output logic                       m_axi4_awlock,
  output logic [3:0]                 m_axi4_awcache,
  output logic [2:0]                 m_axi4_awprot,
  output logic [AXI4_QOS_WIDTH-1:0]  m_axi4_awqos,
  output logic [3:0]                 m_axi4_awregion,
  output logic                       m_axi4_awvalid,
  input  logic                       m_axi4_awready,
  output logic [AXI4_DATA_WIDTH-1:0] m_axi4_wdata,
  output logic [AXI4_STRB_WIDTH-1:0] m_axi4_wstrb,
  output logic                       m_axi4_wlast,
  output logic                       m_axi4_wvalid,
  input  logic                       m_axi4_wready,
  input  logic [AXI4_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                 m_axi4_bresp,
  input  logic                       m_axi4_bvalid,
  output logic                       m_axi4_bready,

  output logic [CNT_WIDTH-1:0]       outstanding,
  output logic [CNT_WIDTH-1:0]       w_credit,
  output logic                       err
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = '1;

  logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0] w_credit_q, w_credit_d;
  logic aw_block, w_block;
  logic aw_hs, wl_hs, b_hs;

  // Reset also blocks both channels so no handshake can slip through while counters are held clear.
  assign aw_block = (outstanding_q == MAX_CNT) | ~aresetn;
  assign w_block  = (w_credit_q == '0) | ~aresetn;

  assign m_axi4_awid     = s_axi4_awid;
  assign m_axi4_awaddr   = s_axi4_awaddr;
  assign m_axi4_awlen    = s_axi4_awlen;
  assign m_axi4_awsize   = s_axi4_awsize;
  assign m_axi4_awburst  = s_axi4_awburst;
  assign m_axi4_awlock   = s_axi4_awlock;
  assign m_axi4_awcache  = s_axi4_awcache;
  assign m_axi4_awprot   = s_axi4_awprot;
  assign m_axi4_awqos    = s_axi4_awqos;
  assign m_axi4_awregion = s_axi4_awregion;
  assign m_axi4_awvalid  = s_axi4_awvalid & ~aw_block;
  assign s_axi4_awready  = m_axi4_awready & ~aw_block;

  assign m_axi4_wdata    = s_axi4_wdata;
  assign m_axi4_wstrb    = s_axi4_wstrb;
  assign m_axi4_wlast    = s_axi4_wlast;
  assign m_axi4_wvalid   = s_axi4_wvalid & ~w_block;
  assign s_axi4_wready   = m_axi4_wready & ~w_block;

  assign s_axi4_bid      = m_axi4_bid;
  assign s_axi4_bresp    = m_axi4_bresp;
  assign s_axi4_bvalid   = m_axi4_bvalid;
  assign m_axi4_bready   = s_axi4_bready;

  assign aw_hs = m_axi4_awvalid & m_axi4_awready;
  assign wl_hs = m_axi4_wvalid & m_axi4_wready & m_axi4_wlast;
  assign b_hs  = m_axi4_bvalid & m_axi4_bready;

  // Counters saturate rather than wrap; a response or wlast with nothing to retire leaves them at zero.
  always_comb begin
    outstanding_d = outstanding_q;
    if (aw_hs && !b_hs) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (b_hs && !aw_hs && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    w_credit_d = w_credit_q;
    if (aw_hs && !wl_hs && (w_credit_q != CNT_FULL)) begin
      w_credit_d = w_credit_q + 1'b1;
    end else if (wl_hs && !aw_hs && (w_credit_q != '0)) begin
      w_credit_d = w_credit_q - 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding_q <= '0;
      w_credit_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      w_credit_q    <= w_credit_d;
    end
  end

  assign outstanding = outstanding_q;
  assign w_credit    = w_credit_q;

`ifdef JELLY_AXI4_WRITE_LIMITER_ERR_EN
  logic err_q;
  logic b_viol, w_viol, resp_err;

  assign b_viol   = b_hs & ~aw_hs & (outstanding_q == '0);
  assign w_viol   = wl_hs & ~aw_hs & (w_credit_q == '0);
  assign resp_err = b_hs & (m_axi4_bresp != 2'b00);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (resp_err || b_viol || w_viol) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jelly_axi4_write_limiter.sv
// Scoreboard bench for jelly_axi4_write_limiter: directed scenarios plus a randomized master/slave phase.
module tb_jelly_axi4_write_limiter;
  localparam int MAX = 2;
`ifdef JELLY_AXI4_WRITE_LIMITER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic aresetn, aclk;
  logic [5:0]  s_axi4_awid;   logic [31:0] s_axi4_awaddr; logic [7:0] s_axi4_awlen;
  logic [2:0]  s_axi4_awsize; logic [1:0]  s_axi4_awburst; logic s_axi4_awlock;
  logic [3:0]  s_axi4_awcache; logic [2:0] s_axi4_awprot; logic [3:0] s_axi4_awqos;
  logic [3:0]  s_axi4_awregion; logic s_axi4_awvalid, s_axi4_awready;
  logic [31:0] s_axi4_wdata; logic [3:0] s_axi4_wstrb; logic s_axi4_wlast, s_axi4_wvalid, s_axi4_wready;
  logic [5:0]  s_axi4_bid; logic [1:0] s_axi4_bresp; logic s_axi4_bvalid, s_axi4_bready;
  logic [5:0]  m_axi4_awid;   logic [31:0] m_axi4_awaddr; logic [7:0] m_axi4_awlen;
  logic [2:0]  m_axi4_awsize; logic [1:0]  m_axi4_awburst; logic m_axi4_awlock;
  logic [3:0]  m_axi4_awcache; logic [2:0] m_axi4_awprot; logic [3:0] m_axi4_awqos;
  logic [3:0]  m_axi4_awregion; logic m_axi4_awvalid, m_axi4_awready;
  logic [31:0] m_axi4_wdata; logic [3:0] m_axi4_wstrb; logic m_axi4_wlast, m_axi4_wvalid, m_axi4_wready;
  logic [5:0]  m_axi4_bid; logic [1:0] m_axi4_bresp; logic m_axi4_bvalid, m_axi4_bready;
  logic [7:0]  outstanding, w_credit;
  logic        err;

  jelly_axi4_write_limiter #(.MAX_OUTSTANDING(MAX)) dut (
    .aresetn(aresetn), .aclk(aclk),
    .s_axi4_awid(s_axi4_awid), .s_axi4_awaddr(s_axi4_awaddr), .s_axi4_awlen(s_axi4_awlen),
    .s_axi4_awsize(s_axi4_awsize), .s_axi4_awburst(s_axi4_awburst), .s_axi4_awlock(s_axi4_awlock),
    .s_axi4_awcache(s_axi4_awcache), .s_axi4_awprot(s_axi4_awprot), .s_axi4_awqos(s_axi4_awqos),
    .s_axi4_awregion(s_axi4_awregion), .s_axi4_awvalid(s_axi4_awvalid), .s_axi4_awready(s_axi4_awready),
    .s_axi4_wdata(s_axi4_wdata), .s_axi4_wstrb(s_axi4_wstrb), .s_axi4_wlast(s_axi4_wlast),
    .s_axi4_wvalid(s_axi4_wvalid), .s_axi4_wready(s_axi4_wready),
    .s_axi4_bid(s_axi4_bid), .s_axi4_bresp(s_axi4_bresp), .s_axi4_bvalid(s_axi4_bvalid),
    .s_axi4_bready(s_axi4_bready),
    .m_axi4_awid(m_axi4_awid), .m_axi4_awaddr(m_axi4_awaddr), .m_axi4_awlen(m_axi4_awlen),
    .m_axi4_awsize(m_axi4_awsize), .m_axi4_awburst(m_axi4_awburst), .m_axi4_awlock(m_axi4_awlock),
    .m_axi4_awcache(m_axi4_awcache), .m_axi4_awprot(m_axi4_awprot), .m_axi4_awqos(m_axi4_awqos),
    .m_axi4_awregion(m_axi4_awregion), .m_axi4_awvalid(m_axi4_awvalid), .m_axi4_awready(m_axi4_awready),
    .m_axi4_wdata(m_axi4_wdata), .m_axi4_wstrb(m_axi4_wstrb), .m_axi4_wlast(m_axi4_wlast),
    .m_axi4_wvalid(m_axi4_wvalid), .m_axi4_wready(m_axi4_wready),
    .m_axi4_bid(m_axi4_bid), .m_axi4_bresp(m_axi4_bresp), .m_axi4_bvalid(m_axi4_bvalid),
    .m_axi4_bready(m_axi4_bready),
    .outstanding(outstanding), .w_credit(w_credit), .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  logic [66:0] aw_q[$];
  logic [36:0] w_q[$];
  logic [7:0]  b_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [66:0] pack_s_aw();
    return {s_axi4_awid, s_axi4_awaddr, s_axi4_awlen, s_axi4_awsize, s_axi4_awburst, s_axi4_awlock,
            s_axi4_awcache, s_axi4_awprot, s_axi4_awqos, s_axi4_awregion};
  endfunction

  function automatic logic [66:0] pack_m_aw();
    return {m_axi4_awid, m_axi4_awaddr, m_axi4_awlen, m_axi4_awsize, m_axi4_awburst, m_axi4_awlock,
            m_axi4_awcache, m_axi4_awprot, m_axi4_awqos, m_axi4_awregion};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue_aw(input logic [5:0] id, input logic [7:0] len);
    s_axi4_awid = id; s_axi4_awaddr = $urandom; s_axi4_awlen = len;
    s_axi4_awsize = 3'($urandom_range(0, 2)); s_axi4_awburst = 2'($urandom_range(0, 2));
    s_axi4_awlock = 1'($urandom); s_axi4_awcache = 4'($urandom); s_axi4_awprot = 3'($urandom);
    s_axi4_awqos = 4'($urandom); s_axi4_awregion = 4'($urandom);
    s_axi4_awvalid = 1'b1;
    aw_q.push_back(pack_s_aw());
  endtask

  task automatic issue_w(input logic last);
    s_axi4_wdata = $urandom; s_axi4_wstrb = 4'($urandom); s_axi4_wlast = last;
    s_axi4_wvalid = 1'b1;
    w_q.push_back({s_axi4_wdata, s_axi4_wstrb, s_axi4_wlast});
  endtask

  task automatic issue_b(input logic [5:0] id, input logic [1:0] resp);
    m_axi4_bid = id; m_axi4_bresp = resp; m_axi4_bvalid = 1'b1;
    b_q.push_back({id, resp});
  endtask

  // Single-beat burst with all readies high: AW, then W one cycle later, then B.
  task automatic one_burst(input logic [1:0] resp);
    logic [5:0] id;
    id = 6'($urandom);
    issue_aw(id, 8'd0); issue_w(1'b1);
    tick(); s_axi4_awvalid = 1'b0;
    tick(); s_axi4_wvalid = 1'b0;
    issue_b(id, resp);
    tick(); m_axi4_bvalid = 1'b0;
  endtask

  // Reference model: outstanding/credit as accepted-minus-retired counts, floored at zero.
  int  mdl_out = 0, mdl_wc = 0;
  bit  err_exp = 1'b0;
  always @(negedge aclk) begin
    bit aw_f, wl_f, b_f;
    logic [66:0] ea; logic [36:0] ew; logic [7:0] eb;
    if (!aresetn) begin
      mdl_out = 0; mdl_wc = 0; err_exp = 1'b0;
    end else begin
      chk("outstanding", outstanding, mdl_out);
      chk("w_credit", w_credit, mdl_wc);
      chk("err", err, err_exp);
      chk("m_awvalid", m_axi4_awvalid, s_axi4_awvalid && (mdl_out != MAX));
      chk("s_awready", s_axi4_awready, m_axi4_awready && (mdl_out != MAX));
      chk("m_wvalid", m_axi4_wvalid, s_axi4_wvalid && (mdl_wc != 0));
      chk("s_wready", s_axi4_wready, m_axi4_wready && (mdl_wc != 0));
      chk("s_bvalid", s_axi4_bvalid, m_axi4_bvalid);
      chk("m_bready", m_axi4_bready, s_axi4_bready);
      if (m_axi4_awvalid && m_axi4_awready) begin
        chk("aw_expected", aw_q.size() != 0, 1'b1);
        if (aw_q.size() != 0) begin
          ea = aw_q.pop_front();
          chk("aw_payload", pack_m_aw(), ea);
          $display("AW id=%0h addr=%08h len=%0d", m_axi4_awid, m_axi4_awaddr, m_axi4_awlen);
        end
      end
      if (m_axi4_wvalid && m_axi4_wready) begin
        chk("w_expected", w_q.size() != 0, 1'b1);
        if (w_q.size() != 0) begin
          ew = w_q.pop_front();
          chk("w_payload", {m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast}, ew);
          $display("W  data=%08h strb=%0h last=%0d", m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast);
        end
      end
      if (s_axi4_bvalid && s_axi4_bready) begin
        chk("b_expected", b_q.size() != 0, 1'b1);
        if (b_q.size() != 0) begin
          eb = b_q.pop_front();
          chk("b_payload", {s_axi4_bid, s_axi4_bresp}, eb);
          $display("B  id=%0h resp=%0d", s_axi4_bid, s_axi4_bresp);
        end
      end
      aw_f = s_axi4_awvalid && s_axi4_awready;
      wl_f = s_axi4_wvalid && s_axi4_wready && s_axi4_wlast;
      b_f  = s_axi4_bvalid && s_axi4_bready;
      if (ERR_EN && b_f && ((s_axi4_bresp != 2'b00) || (mdl_out == 0 && !aw_f))) err_exp = 1'b1;
      mdl_out = mdl_out + int'(aw_f) - int'(b_f); if (mdl_out < 0) mdl_out = 0;
      mdl_wc  = mdl_wc + int'(aw_f) - int'(wl_f); if (mdl_wc < 0) mdl_wc = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  aws_left, beat, slv_done, cyc;
    int  wlen_q[$];
    logic [5:0] slv_id_q[$];
    logic [5:0] cap_id;
    bit  aw_f, w_f, b_f, maw_f, mwl_f;

    aresetn = 1'b0;
    s_axi4_awid = '0; s_axi4_awaddr = '0; s_axi4_awlen = '0; s_axi4_awsize = '0; s_axi4_awburst = '0;
    s_axi4_awlock = 1'b0; s_axi4_awcache = '0; s_axi4_awprot = '0; s_axi4_awqos = '0; s_axi4_awregion = '0;
    s_axi4_awvalid = 1'b0; s_axi4_wdata = '0; s_axi4_wstrb = '0; s_axi4_wlast = 1'b0; s_axi4_wvalid = 1'b0;
    s_axi4_bready = 1'b0; m_axi4_awready = 1'b1; m_axi4_wready = 1'b1;
    m_axi4_bid = '0; m_axi4_bresp = '0; m_axi4_bvalid = 1'b0;
    s_axi4_awvalid = 1'b1; s_axi4_wvalid = 1'b1;
    #1;
    chk("rst_outstanding", outstanding, 8'd0);
    chk("rst_w_credit", w_credit, 8'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_awready", s_axi4_awready, 1'b0);
    chk("rst_m_wvalid", m_axi4_wvalid, 1'b0);
    s_axi4_awvalid = 1'b0; s_axi4_wvalid = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // Outstanding cap: third AW stalls until one response retires a burst.
    issue_aw(6'd1, 8'd0); tick();
    issue_aw(6'd2, 8'd0); tick();
    issue_aw(6'd3, 8'd0);
    chk("s1_stall_awready", s_axi4_awready, 1'b0);
    chk("s1_outstanding_max", outstanding, 8'd2);
    tick();
    chk("s1_still_stalled", s_axi4_awready, 1'b0);
    issue_b(6'd1, 2'b00); s_axi4_bready = 1'b1;
    tick(); m_axi4_bvalid = 1'b0; s_axi4_bready = 1'b0;
    chk("s1_awready_after_b", s_axi4_awready, 1'b1);
    tick(); s_axi4_awvalid = 1'b0;
    chk("s1_third_accepted", outstanding, 8'd2);
    chk("s1_credit3", w_credit, 8'd3);
    for (int i = 0; i < 3; i++) begin issue_w(1'b1); tick(); end
    s_axi4_wvalid = 1'b0;
    chk("s1_credit_drained", w_credit, 8'd0);
    s_axi4_bready = 1'b1;
    for (int i = 0; i < 2; i++) begin issue_b(6'(i + 2), 2'b00); tick(); end
    m_axi4_bvalid = 1'b0; s_axi4_bready = 1'b0;
    chk("s1_out_drained", outstanding, 8'd0);

    // W offered before its AW is held back until the cycle after aw_hs.
    issue_w(1'b0); tick();
    chk("s2_w_blocked", m_axi4_wvalid, 1'b0); tick();
    issue_aw(6'd5, 8'd3);
    chk("s2_w_blocked_same_cycle", m_axi4_wvalid, 1'b0);
    tick(); s_axi4_awvalid = 1'b0;
    chk("s2_credit_1", w_credit, 8'd1);
    chk("s2_w_after_aw", m_axi4_wvalid, 1'b1);
    tick(); issue_w(1'b0); tick(); issue_w(1'b0); tick(); issue_w(1'b1);
    chk("s2_credit_mid_burst", w_credit, 8'd1);
    tick(); s_axi4_wvalid = 1'b0;
    chk("s2_credit_0", w_credit, 8'd0);
    issue_b(6'd5, 2'b00); s_axi4_bready = 1'b1;
    tick(); m_axi4_bvalid = 1'b0; s_axi4_bready = 1'b0;

    // Simultaneous increment and decrement on both counters.
    issue_aw(6'd6, 8'd0); tick();
    issue_aw(6'd7, 8'd0); issue_w(1'b1); issue_b(6'd6, 2'b00); s_axi4_bready = 1'b1;
    tick(); s_axi4_awvalid = 1'b0; s_axi4_wvalid = 1'b0; m_axi4_bvalid = 1'b0;
    chk("s3_out_hold", outstanding, 8'd1);
    chk("s3_credit_hold", w_credit, 8'd1);
    issue_w(1'b1); tick(); s_axi4_wvalid = 1'b0;
    issue_b(6'd7, 2'b00); tick(); m_axi4_bvalid = 1'b0; s_axi4_bready = 1'b0;

    // Randomized upstream master and downstream slave.
    aws_left = 40; beat = 0; slv_done = 0; cyc = 0;
    while (cyc < 5000 && !(aws_left == 0 && wlen_q.size() == 0 && slv_id_q.size() == 0 &&
                           !s_axi4_awvalid && !m_axi4_bvalid && slv_done == 0)) begin
      cyc++;
      @(negedge aclk);
      aw_f  = s_axi4_awvalid && s_axi4_awready;
      w_f   = s_axi4_wvalid && s_axi4_wready;
      b_f   = s_axi4_bvalid && s_axi4_bready;
      maw_f = m_axi4_awvalid && m_axi4_awready;
      mwl_f = m_axi4_wvalid && m_axi4_wready && m_axi4_wlast;
      cap_id = m_axi4_awid;
      tick();
      if (maw_f) slv_id_q.push_back(cap_id);
      if (mwl_f) slv_done++;
      if (aw_f) s_axi4_awvalid = 1'b0;
      if (!s_axi4_awvalid && aws_left > 0 && $urandom_range(0, 2) == 0) begin
        beat = beat;
        wlen_q.push_back($urandom_range(0, 3));
        issue_aw(6'($urandom), 8'(wlen_q[$]));
        aws_left--;
      end
      if (w_f) begin
        if (s_axi4_wlast) begin void'(wlen_q.pop_front()); beat = 0; end
        else beat++;
        s_axi4_wvalid = 1'b0;
      end
      if (!s_axi4_wvalid && wlen_q.size() > 0 && $urandom_range(0, 1) == 1) issue_w(beat == wlen_q[0]);
      if (b_f) m_axi4_bvalid = 1'b0;
      if (!m_axi4_bvalid && slv_done > 0 && slv_id_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        issue_b(slv_id_q.pop_front(), 2'b00);
        slv_done--;
      end
      m_axi4_awready = 1'($urandom); m_axi4_wready = 1'($urandom); s_axi4_bready = 1'($urandom);
    end
    chk("rand_drained_in_budget", cyc < 5000, 1'b1);
    m_axi4_awready = 1'b1; m_axi4_wready = 1'b1; s_axi4_bready = 1'b1;
    tick();
    chk("rand_out_zero", outstanding, 8'd0);

    // Error response is sticky across later OKAY responses.
    one_burst(2'b10);
    chk("err_slverr", err, ERR_EN);
    one_burst(2'b00);
    chk("err_sticky", err, ERR_EN);

    // Asynchronous reset mid-burst, on beat 2 of 4.
    issue_aw(6'd9, 8'd3); tick(); s_axi4_awvalid = 1'b0;
    issue_w(1'b0); tick(); issue_w(1'b0); tick(); issue_w(1'b0);
    issue_aw(6'd10, 8'd0);
    chk("pre_rst_out", outstanding, 8'd1);
    chk("pre_rst_m_wvalid", m_axi4_wvalid, 1'b1);
    #3 aresetn = 1'b0;
    #1;
    chk("arst_outstanding", outstanding, 8'd0);
    chk("arst_w_credit", w_credit, 8'd0);
    chk("arst_err", err, 1'b0);
    chk("arst_s_awready", s_axi4_awready, 1'b0);
    chk("arst_m_awvalid", m_axi4_awvalid, 1'b0);
    chk("arst_s_wready", s_axi4_wready, 1'b0);
    chk("arst_m_wvalid", m_axi4_wvalid, 1'b0);
    s_axi4_bready = 1'b0; m_axi4_bvalid = 1'b1; #1;
    chk("arst_b_pass", s_axi4_bvalid, 1'b1);
    s_axi4_bready = 1'b1; #1;
    chk("arst_bready_pass", m_axi4_bready, 1'b1);
    s_axi4_bready = 1'b0; m_axi4_bvalid = 1'b0;
    s_axi4_awvalid = 1'b0; s_axi4_wvalid = 1'b0;
    aw_q.delete(); w_q.delete(); b_q.delete();
    tick(); tick();
    #2 aresetn = 1'b1;
    tick();

    // Stray response with nothing outstanding.
    issue_b(6'd11, 2'b00); s_axi4_bready = 1'b1;
    tick(); m_axi4_bvalid = 1'b0;
    chk("stray_out_zero", outstanding, 8'd0);
    chk("stray_err", err, ERR_EN);
    one_burst(2'b00);
    chk("post_rst_out", outstanding, 8'd0);
    chk("post_rst_credit", w_credit, 8'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
